// File: rtl/dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// dds_sweep_ctrl
//
// Frequency-sweep sequencer for the DDS sine generator. A start pulse latches
// the sweep configuration into shadow registers. The block then steps the DDS
// tuning word linearly from f_start up to f_stop, and holds each point for
// dwell+1 cycles. Sweeps can be single shot or repeat continuously, and an
// abort ends them at once.
//
// Ports
//   clk          : single clock, all logic on its rising edge
//   rst          : synchronous active-high reset
//   start        : begin a sweep (honoured only when idle)
//   abort        : stop immediately (priority over start)
//   cfg_f_start  : first tuning word
//   cfg_f_stop   : last tuning word (unsigned, sweep never exceeds it)
//   cfg_step     : increment per point
//   cfg_dwell    : each point is held for cfg_dwell+1 cycles
//   cfg_repeat   : 1 = restart at f_start after the last point, 0 = single shot
//   delta_phase  : registered tuning word to the DDS
//   dds_rst      : registered one-cycle pulse that resets the DDS accumulator
//   busy         : high while loading or sweeping
//   done         : one-cycle pulse on normal completion
//   sweep_cnt    : completed sweeps since reset, wraps modulo 2^16
// ---------------------------------------------------------------------------
module dds_sweep_ctrl #(
    parameter int PHASE_WIDTH = 32,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [PHASE_WIDTH-1:0] cfg_f_start,
    input  logic [PHASE_WIDTH-1:0] cfg_f_stop,
    input  logic [PHASE_WIDTH-1:0] cfg_step,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic                   cfg_repeat,
    output logic [PHASE_WIDTH-1:0] delta_phase,
    output logic                   dds_rst,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            sweep_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // State, output and shadow-configuration registers
    // -----------------------------------------------------------------------
    state_t                 state_q,       state_d;
    logic [PHASE_WIDTH-1:0] delta_phase_q, delta_phase_d;
    logic                   dds_rst_q,     dds_rst_d;
    logic                   busy_q,        busy_d;
    logic                   done_q,        done_d;
    logic [15:0]            sweep_cnt_q,   sweep_cnt_d;
    logic [DWELL_WIDTH-1:0] cnt_q,         cnt_d;

    logic [PHASE_WIDTH-1:0] f_start_q,     f_start_d;
    logic [PHASE_WIDTH-1:0] f_stop_q,      f_stop_d;
    logic [PHASE_WIDTH-1:0] step_q,        step_d;
    logic [DWELL_WIDTH-1:0] dwell_q,       dwell_d;
    logic                   repeat_q,      repeat_d;

    // -----------------------------------------------------------------------
    // Next-point arithmetic
    // -----------------------------------------------------------------------
    // The sum is one bit wider than the tuning word so a carry out of the top
    // bit is visible. A carry, or a sum past f_stop, clamps the next point to
    // f_stop, so the sweep never wraps to a small frequency.
    logic [PHASE_WIDTH:0]   sum;
    logic [PHASE_WIDTH-1:0] next_point;
    logic                   is_last;

    always_comb begin
        sum        = {1'b0, delta_phase_q} + {1'b0, step_q};
        next_point = sum[PHASE_WIDTH-1:0];
        if (sum[PHASE_WIDTH] || (sum[PHASE_WIDTH-1:0] > f_stop_q)) begin
            next_point = f_stop_q;
        end
        // A zero step would never advance, so it is a one-point sweep. When
        // f_stop < f_start the first point already satisfies >=, which gives
        // the single-f_start-point behaviour.
        is_last = (step_q == '0) || (delta_phase_q >= f_stop_q);
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        delta_phase_d = delta_phase_q;
        dds_rst_d     = 1'b0;          // dds_rst and done are single-cycle
        busy_d        = busy_q;
        done_d        = 1'b0;
        sweep_cnt_d   = sweep_cnt_q;
        cnt_d         = cnt_q;
        f_start_d     = f_start_q;
        f_stop_d      = f_stop_q;
        step_d        = step_q;
        dwell_d       = dwell_q;
        repeat_d      = repeat_q;

        unique case (state_q)
            ST_IDLE: begin
                delta_phase_d = '0;
                busy_d        = 1'b0;
                if (start && !abort) begin
                    // Snapshot the configuration. Later changes to cfg_* do
                    // not affect this sweep.
                    f_start_d = cfg_f_start;
                    f_stop_d  = cfg_f_stop;
                    step_d    = cfg_step;
                    dwell_d   = cfg_dwell;
                    repeat_d  = cfg_repeat;
                    busy_d    = 1'b1;
                    state_d   = ST_LOAD;
                end
            end

            ST_LOAD: begin
                // The first tuning word and the DDS phase reset show up at the
                // same edge, so the sine restarts from phase 0 on f_start.
                delta_phase_d = f_start_q;
                dds_rst_d     = 1'b1;
                cnt_d         = dwell_q;
                state_d       = ST_SWEEP;
            end

            ST_SWEEP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_WIDTH'(1);
                end else if (!is_last) begin
                    delta_phase_d = next_point;
                    cnt_d         = dwell_q;
                end else begin
                    sweep_cnt_d = sweep_cnt_q + 16'd1;
                    if (repeat_q) begin
                        // Wrap back to f_start with no gap cycle. The DDS
                        // phase is not reset, so the output stays continuous.
                        delta_phase_d = f_start_q;
                        cnt_d         = dwell_q;
                    end else begin
                        delta_phase_d = '0;
                        busy_d        = 1'b0;
                        done_d        = 1'b1;
                        state_d       = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                // The done pulse was registered on entry. start is ignored
                // here, so the earliest restart is from IDLE.
                delta_phase_d = '0;
                busy_d        = 1'b0;
                state_d       = ST_IDLE;
            end

            default: begin
                delta_phase_d = '0;
                busy_d        = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase

        // An abort overrides whatever the active states decided. The aborted
        // sweep is not counted, because sweep_cnt_d falls back to its held
        // value.
        if (abort && (state_q != ST_IDLE)) begin
            state_d       = ST_IDLE;
            delta_phase_d = '0;
            dds_rst_d     = 1'b0;
            busy_d        = 1'b0;
            done_d        = 1'b0;
            sweep_cnt_d   = sweep_cnt_q;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            delta_phase_q <= '0;
            dds_rst_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            sweep_cnt_q   <= '0;
            cnt_q         <= '0;
            f_start_q     <= '0;
            f_stop_q      <= '0;
            step_q        <= '0;
            dwell_q       <= '0;
            repeat_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            delta_phase_q <= delta_phase_d;
            dds_rst_q     <= dds_rst_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            sweep_cnt_q   <= sweep_cnt_d;
            cnt_q         <= cnt_d;
            f_start_q     <= f_start_d;
            f_stop_q      <= f_stop_d;
            step_q        <= step_d;
            dwell_q       <= dwell_d;
            repeat_q      <= repeat_d;
        end
    end

    assign delta_phase = delta_phase_q;
    assign dds_rst     = dds_rst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign sweep_cnt   = sweep_cnt_q;

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer that drives the `delta_phase` input and the synchronous `rst` of the team's DDS sine generator. On a start pulse it loads a latched sweep configuration and steps the tuning word linearly from a start to a stop frequency, holding each point for a programmable dwell. It supports single-shot or continuous (repeat) sweeps and abort. It sits between the control/register block and the DDS.

## Interface
- `PHASE_WIDTH`, default 32: tuning-word width; must match the DDS.
- `DWELL_WIDTH`, default 16: dwell counter width.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a sweep; honoured only in IDLE.
- `abort` in 1: stop immediately; has priority over `start`.
- `cfg_f_start` in PHASE_WIDTH: first tuning word.
- `cfg_f_stop` in PHASE_WIDTH: last tuning word (unsigned).
- `cfg_step` in PHASE_WIDTH: increment per point.
- `cfg_dwell` in DWELL_WIDTH: each point is held for `cfg_dwell+1` cycles.
- `cfg_repeat` in 1: 1 = restart at `f_start` after the last point; 0 = single shot.
- `delta_phase` out PHASE_WIDTH: registered tuning word to the DDS.
- `dds_rst` out 1: registered one-cycle pulse that resets the DDS phase accumulator.
- `busy` out 1: high in LOAD and SWEEP.
- `done` out 1: one-cycle pulse on normal completion.
- `sweep_cnt` out 16: count of completed sweeps since reset; wraps modulo 2^16.

## Operation
- **States:** IDLE, LOAD, SWEEP, DONE.
- **Reset.** `rst` puts the block in IDLE and clears every output: `delta_phase`=0, `dds_rst`=0, `busy`=0, `done`=0, `sweep_cnt`=0. It also clears the shadow config and the dwell counter. Reset mid-sweep takes effect at the next edge with no `done` pulse.
- **IDLE.** `delta_phase`=0.
  - `start`=1 and `abort`=0: latch all `cfg_*` into shadow registers and go to LOAD.
  - `cfg_*` changes after the latch have no effect until the next start.
- **LOAD** (always one cycle): `delta_phase`<=`f_start`, `dds_rst`<=1, `cnt`<=`dwell`, then go to SWEEP.
- **SWEEP.**
  - If `cnt`≠0: decrement `cnt`.
  - If `cnt`=0 and the current point is **not** last: `delta_phase`<=`next`, `cnt`<=`dwell`.
  - If `cnt`=0 and the current point **is** last:
    - Increment `sweep_cnt`.
    - With `repeat`=1: `delta_phase`<=`f_start` and `cnt`<=`dwell`, staying in SWEEP. Phase stays continuous (no `dds_rst`).
    - With `repeat`=0: go to DONE.
- **Last point:** `step`==0, or `delta_phase` ≥ `f_stop`. If `f_stop` < `f_start`, only `f_start` is output.
- **Next point:** `sum` = `delta_phase` + `step`, computed PHASE_WIDTH+1 wide. `next` = `f_stop` if `sum` carries out or `sum` > `f_stop`; otherwise `next` = `sum[PHASE_WIDTH-1:0]`. The sweep never exceeds `f_stop` and never wraps.
- **DONE** (one cycle): `done`=1, `busy`=0, `delta_phase`=0, then go to IDLE. `start` is ignored in DONE.
- **abort**, when high in LOAD, SWEEP or DONE: next state IDLE.
  - `delta_phase`<=0, `dds_rst`<=0, `busy`<=0, `done`<=0.
  - `sweep_cnt` is not incremented for the aborted sweep.
- **`start` while busy:** ignored.

## Timing
- `start` sampled at edge E0. After E0: state LOAD, `busy`=1.
- After E1: `delta_phase`=`f_start` and `dds_rst`=1 for exactly one cycle. The DDS therefore restarts its phase coincident with the first tuning word.
- Each tuning word is stable for exactly `dwell+1` cycles, with no gap cycles between points or between repeated sweeps.
- Single shot with N points: `delta_phase` returns to 0 and `done`=1 at edge E1 + N·(dwell+1). `busy` falls at the same edge.
- `sweep_cnt` updates at the same edge as the last point's hold expires.
- Earliest restart is `start` sampled in the cycle after DONE, i.e. in IDLE.
- `abort` takes effect at the first edge at which it is sampled high; latency is 1 cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Basic sweep.** `f_start`=100, `f_stop`=130, `step`=10, `dwell`=2, `repeat`=0.
  - `delta_phase` = 100,100,100,110×3,120×3,130×3, then 0.
  - `dds_rst` pulses once, aligned with the first 100.
  - `done` pulses once, 12 cycles after that first 100. `sweep_cnt`=1.
- **Clamp.** `step`=12 with the same endpoints → points 100,112,124,130. Add a case with `f_stop`<`f_start` (200→100) → a single 200 point, then `done`.
- **Overflow clamp.** `f_start`=0xFFFFFFF0, `f_stop`=0xFFFFFFFF, `step`=0x20, `dwell`=0 → 0xFFFFFFF0, 0xFFFFFFFF, then `done`. No wrap to a small value.
- **Repeat then abort.** `repeat`=1, `f_start`=0, `f_stop`=20, `step`=10, `dwell`=1.
  - Sequence 0,0,10,10,20,20,0,0,… with no `dds_rst` on wraps.
  - `sweep_cnt` increments every 6 cycles.
  - `abort` mid-point → `delta_phase`=0 and `busy`=0 next cycle, no `done`.
- **Busy and config isolation.** Pulse `start` mid-sweep and change every `cfg_*` → sequence unchanged. A new `start` in IDLE picks up the new config.
- **Reset mid-sweep.** `rst` while in SWEEP → all outputs 0 next cycle, `sweep_cnt`=0. Assert `start` and `abort` together in IDLE → stays IDLE.
